// File: rtl/branch_target_buffer.sv
// Four-entry direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch performs a combinational lookup; the memory stage writes back resolved outcomes and flags mispredictions.
module branch_target_buffer (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] if_pc,
  output logic        btb_taken,
  output logic [31:0] btb_target,
  output logic [1:0]  btb_index,
  input  logic        mem_valid,
  input  logic        mem_beq,
  input  logic        mem_bne,
  input  logic [31:0] mem_pc,
  input  logic        mem_brTake,
  input  logic [31:0] mem_brTarget,
  input  logic        mem_btb_taken,
  input  logic [31:0] mem_btb_target,
  input  logic [1:0]  mem_btb_index,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int ENTRIES = 4;

  logic [3:0]  valid_r;
  logic [27:0] tag_r    [ENTRIES];
  logic [31:0] target_r [ENTRIES];
  logic [1:0]  ctr_r    [ENTRIES];
  logic [31:0] stat_branches_r;
  logic [31:0] stat_mispredicts_r;

  logic [1:0]  lk_idx_s;
  logic        lk_hit_s;
  logic        lk_taken_s;
  logic [31:0] lk_target_s;

  logic        upd_s;
  logic [1:0]  upd_idx_s;
  logic        upd_match_s;
  logic        wr_s;
  logic [27:0] tag_nxt_s;
  logic [31:0] target_nxt_s;
  logic [1:0]  ctr_nxt_s;
  logic        mispredict_s;
  logic [31:0] correct_pc_s;

  // Saturating 2-bit counter step toward taken (up) or not-taken (down).
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    case ({taken, c})
      3'b1_00: r = 2'b01;
      3'b1_01: r = 2'b10;
      3'b1_10: r = 2'b11;
      3'b1_11: r = 2'b11;
      3'b0_00: r = 2'b00;
      3'b0_01: r = 2'b00;
      3'b0_10: r = 2'b01;
      3'b0_11: r = 2'b10;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  // Fetch-side lookup from current state; no bypass from a same-cycle update.
  always_comb begin
    lk_idx_s    = if_pc[3:2];
    lk_hit_s    = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == if_pc[31:4]);
    lk_taken_s  = lk_hit_s && ctr_r[lk_idx_s][1];
    lk_target_s = if_pc + 32'd4;
    if (lk_taken_s) begin
      lk_target_s = target_r[lk_idx_s];
    end else begin
      lk_target_s = if_pc + 32'd4;
    end
  end

  assign btb_taken  = lk_taken_s;
  assign btb_target = lk_target_s;
  assign btb_index  = lk_idx_s;

  // Write-back decision: train a matching entry, allocate on a taken miss.
  always_comb begin
    upd_s        = mem_valid && (mem_beq || mem_bne);
    upd_idx_s    = mem_btb_index;
    upd_match_s  = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == mem_pc[31:4]);
    wr_s         = 1'b0;
    tag_nxt_s    = tag_r[upd_idx_s];
    target_nxt_s = target_r[upd_idx_s];
    ctr_nxt_s    = ctr_r[upd_idx_s];
    if (upd_s && upd_match_s) begin
      wr_s      = 1'b1;
      ctr_nxt_s = ctr_step(ctr_r[upd_idx_s], mem_brTake);
      if (mem_brTake) begin
        target_nxt_s = mem_brTarget;
      end else begin
        target_nxt_s = target_r[upd_idx_s];
      end
    end else if (upd_s && mem_brTake) begin
      wr_s         = 1'b1;
      tag_nxt_s    = mem_pc[31:4];
      target_nxt_s = mem_brTarget;
      ctr_nxt_s    = 2'b10;
    end else begin
      wr_s = 1'b0;
    end
  end

  // Misprediction detection and redirect PC for the fetch flush.
  always_comb begin
    mispredict_s = upd_s && ((mem_btb_taken != mem_brTake) ||
                             (mem_brTake && (mem_btb_target != mem_brTarget)));
    correct_pc_s = mem_pc + 32'd4;
    if (mem_brTake) begin
      correct_pc_s = mem_brTarget;
    end else begin
      correct_pc_s = mem_pc + 32'd4;
    end
  end

  assign mispredict = mispredict_s;
  assign correct_pc = correct_pc_s;

  // Entry storage; reset leaves counters weakly not-taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_r <= 4'b0000;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_r[i]    <= 28'd0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (wr_s) begin
      valid_r[upd_idx_s]  <= 1'b1;
      tag_r[upd_idx_s]    <= tag_nxt_s;
      target_r[upd_idx_s] <= target_nxt_s;
      ctr_r[upd_idx_s]    <= ctr_nxt_s;
    end
  end

  // Branch and mispredict statistics, wrapping naturally at 2^32.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_branches_r    <= 32'd0;
      stat_mispredicts_r <= 32'd0;
    end else begin
      if (upd_s) begin
        stat_branches_r <= stat_branches_r + 32'd1;
      end
      if (mispredict_s) begin
        stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_branches_r;
  assign stat_mispredicts = stat_mispredicts_r;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: a behavioural model feeds an expected-result
// queue each cycle, sampled DUT outputs are queued alongside and compared per scenario.
module tb_branch_target_buffer;

  logic        CLK;
  logic        RST;
  logic [31:0] if_pc;
  logic        btb_taken;
  logic [31:0] btb_target;
  logic [1:0]  btb_index;
  logic        mem_valid, mem_beq, mem_bne;
  logic [31:0] mem_pc;
  logic        mem_brTake;
  logic [31:0] mem_brTarget;
  logic        mem_btb_taken;
  logic [31:0] mem_btb_target;
  logic [1:0]  mem_btb_index;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  int checks = 0;
  int failures = 0;

  branch_target_buffer dut (
    .CLK(CLK), .RST(RST), .if_pc(if_pc),
    .btb_taken(btb_taken), .btb_target(btb_target), .btb_index(btb_index),
    .mem_valid(mem_valid), .mem_beq(mem_beq), .mem_bne(mem_bne), .mem_pc(mem_pc),
    .mem_brTake(mem_brTake), .mem_brTarget(mem_brTarget),
    .mem_btb_taken(mem_btb_taken), .mem_btb_target(mem_btb_target), .mem_btb_index(mem_btb_index),
    .mispredict(mispredict), .correct_pc(correct_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  index;
    logic        mp;
    logic [31:0] cpc;
    logic [31:0] sb;
    logic [31:0] sm;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  // Behavioural reference of the buffer
  logic        m_valid [4];
  logic [27:0] m_tag   [4];
  logic [31:0] m_tgt   [4];
  logic [1:0]  m_ctr   [4];
  logic [31:0] m_br, m_mp;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 28'd0; m_tgt[i] = 32'd0; m_ctr[i] = 2'b01;
    end
    m_br = 32'd0; m_mp = 32'd0;
  endtask

  function automatic logic [34:0] m_lookup(input logic [31:0] pc);
    logic [1:0] i;
    logic hit, tk;
    i   = pc[3:2];
    hit = m_valid[i] && (m_tag[i] == pc[31:4]);
    tk  = hit && m_ctr[i][1];
    return {tk, (tk ? m_tgt[i] : pc + 32'd4), i};
  endfunction

  function automatic logic m_mispredict();
    logic upd;
    upd = mem_valid && (mem_beq || mem_bne);
    return upd && ((mem_btb_taken != mem_brTake) || (mem_brTake && mem_btb_target != mem_brTarget));
  endfunction

  task automatic model_update();
    logic [1:0] u;
    if (mem_valid && (mem_beq || mem_bne)) begin
      u = mem_btb_index;
      if (m_mispredict()) m_mp = m_mp + 32'd1;
      m_br = m_br + 32'd1;
      if (m_valid[u] && m_tag[u] == mem_pc[31:4]) begin
        if (mem_brTake) begin
          if (m_ctr[u] != 2'd3) m_ctr[u] = m_ctr[u] + 2'd1;
          m_tgt[u] = mem_brTarget;
        end else begin
          if (m_ctr[u] != 2'd0) m_ctr[u] = m_ctr[u] - 2'd1;
        end
      end else if (mem_brTake) begin
        m_valid[u] = 1'b1; m_tag[u] = mem_pc[31:4]; m_tgt[u] = mem_brTarget; m_ctr[u] = 2'b10;
      end
    end
  endtask

  // Present a resolved branch with the prediction fetch would have produced for it
  task automatic set_upd(input logic [31:0] pc, input logic is_bne, input logic take, input logic [31:0] tgt);
    logic [34:0] lk;
    lk = m_lookup(pc);
    mem_valid = 1'b1; mem_beq = !is_bne; mem_bne = is_bne;
    mem_pc = pc; mem_brTake = take; mem_brTarget = tgt;
    mem_btb_taken = lk[34]; mem_btb_target = lk[33:2]; mem_btb_index = pc[3:2];
  endtask

  task automatic idle_mem();
    mem_valid = 1'b0; mem_beq = 1'b0; mem_bne = 1'b0;
  endtask

  // One clock: queue the model expectation, sample the DUT mid-cycle, advance model at the edge
  task automatic cycle(input string name);
    rec_t e, o;
    logic [34:0] lk;
    lk = m_lookup(if_pc);
    e.name = name; e.taken = lk[34]; e.target = lk[33:2]; e.index = lk[1:0];
    e.mp = m_mispredict();
    e.cpc = mem_brTake ? mem_brTarget : mem_pc + 32'd4;
    e.sb = m_br; e.sm = m_mp;
    exp_q.push_back(e);
    @(negedge CLK);
    o.name = name; o.taken = btb_taken; o.target = btb_target; o.index = btb_index;
    o.mp = mispredict; o.cpc = correct_pc; o.sb = stat_branches; o.sm = stat_mispredicts;
    obs_q.push_back(o);
    @(posedge CLK);
    if (!RST) model_update();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    if_pc = 32'h0000_0040;
    idle_mem();
    #1;
    checks++; if (btb_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%0b want=0", btb_taken); end
    checks++; if (btb_target !== 32'h0000_0044) begin failures++; $display("FAIL reset_target got=%h want=00000044", btb_target); end
    checks++; if (btb_index !== 2'd0) begin failures++; $display("FAIL reset_index got=%0d want=0", btb_index); end
    checks++; if ({stat_branches, stat_mispredicts} !== 64'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d want=0/0", stat_branches, stat_mispredicts); end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_allocate();
    rec_t e, o;
    set_upd(32'h48, 1'b0, 1'b1, 32'h100);
    if_pc = 32'h48;
    cycle("alloc_upd");
    o = obs_q[$];
    checks++; if (o.mp !== 1'b1 || o.cpc !== 32'h100) begin failures++; $display("FAIL alloc_mispredict got=%0b/%h want=1/00000100", o.mp, o.cpc); end
    checks++; if (o.taken !== 1'b0) begin failures++; $display("FAIL same_cycle_no_bypass got=%0b want=0", o.taken); end
    idle_mem();
    cycle("alloc_lookup");
    o = obs_q[$];
    checks++; if ({o.taken, o.target, o.index} !== {1'b1, 32'h100, 2'd2}) begin failures++; $display("FAIL alloc_lookup got=%0b/%h/%0d want=1/00000100/2", o.taken, o.target, o.index); end
    checks++; if (o.sb !== 32'd1 || o.sm !== 32'd1) begin failures++; $display("FAIL alloc_stats got=%0d/%0d want=1/1", o.sb, o.sm); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if ({o.taken, o.target, o.index} !== {e.taken, e.target, e.index}) begin failures++; $display("FAIL %s lookup got=%0b/%h/%0d want=%0b/%h/%0d", e.name, o.taken, o.target, o.index, e.taken, e.target, e.index); end
      checks++; if (o.mp !== e.mp) begin failures++; $display("FAIL %s mispredict got=%0b want=%0b", e.name, o.mp, e.mp); end
      if (e.mp) begin checks++; if (o.cpc !== e.cpc) begin failures++; $display("FAIL %s correct_pc got=%h want=%h", e.name, o.cpc, e.cpc); end end
      checks++; if ({o.sb, o.sm} !== {e.sb, e.sm}) begin failures++; $display("FAIL %s stats got=%0d/%0d want=%0d/%0d", e.name, o.sb, o.sm, e.sb, e.sm); end
    end
  endtask

  task automatic test_counter();
    rec_t e, o;
    if_pc = 32'h48;
    for (int i = 0; i < 2; i++) begin
      set_upd(32'h48, 1'b1, 1'b0, 32'h0);
      cycle("ctr_down");
    end
    idle_mem();
    cycle("ctr_zero_lookup");
    o = obs_q[$];
    checks++; if ({o.taken, o.target} !== {1'b0, 32'h4C}) begin failures++; $display("FAIL ctr_zero got=%0b/%h want=0/0000004c", o.taken, o.target); end
    for (int i = 0; i < 4; i++) begin
      set_upd(32'h48, 1'b0, 1'b1, 32'h100);
      cycle("ctr_up");
    end
    mem_valid = 1'b1; mem_beq = 1'b0; mem_bne = 1'b0;
    mem_pc = 32'h48; mem_brTake = 1'b1; mem_brTarget = 32'h300;
    mem_btb_taken = 1'b0; mem_btb_target = 32'h4C; mem_btb_index = 2'd2;
    cycle("jal_ignored");
    set_upd(32'h48, 1'b0, 1'b0, 32'h0);
    cycle("ctr_sat_down");
    idle_mem();
    cycle("ctr_sat_lookup");
    o = obs_q[$];
    checks++; if ({o.taken, o.target} !== {1'b1, 32'h100}) begin failures++; $display("FAIL ctr_saturate got=%0b/%h want=1/00000100", o.taken, o.target); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if ({o.taken, o.target, o.index} !== {e.taken, e.target, e.index}) begin failures++; $display("FAIL %s lookup got=%0b/%h/%0d want=%0b/%h/%0d", e.name, o.taken, o.target, o.index, e.taken, e.target, e.index); end
      checks++; if (o.mp !== e.mp) begin failures++; $display("FAIL %s mispredict got=%0b want=%0b", e.name, o.mp, e.mp); end
      if (e.mp) begin checks++; if (o.cpc !== e.cpc) begin failures++; $display("FAIL %s correct_pc got=%h want=%h", e.name, o.cpc, e.cpc); end end
      checks++; if ({o.sb, o.sm} !== {e.sb, e.sm}) begin failures++; $display("FAIL %s stats got=%0d/%0d want=%0d/%0d", e.name, o.sb, o.sm, e.sb, e.sm); end
    end
  endtask

  task automatic test_alias();
    rec_t e, o;
    if_pc = 32'h58;
    set_upd(32'h58, 1'b0, 1'b1, 32'h200);
    cycle("alias_alloc");
    mem_valid = 1'b0; mem_beq = 1'b1; mem_pc = 32'h58; mem_brTake = 1'b0;
    cycle("alias_stalled");
    cycle("alias_hit_new");
    o = obs_q[$];
    checks++; if ({o.taken, o.target, o.index} !== {1'b1, 32'h200, 2'd2}) begin failures++; $display("FAIL alias_new got=%0b/%h/%0d want=1/00000200/2", o.taken, o.target, o.index); end
    if_pc = 32'h48;
    cycle("alias_old_miss");
    o = obs_q[$];
    checks++; if ({o.taken, o.target} !== {1'b0, 32'h4C}) begin failures++; $display("FAIL alias_old got=%0b/%h want=0/0000004c", o.taken, o.target); end
    set_upd(32'h58, 1'b1, 1'b1, 32'h240);
    cycle("wrong_target");
    o = obs_q[$];
    checks++; if (o.mp !== 1'b1 || o.cpc !== 32'h240) begin failures++; $display("FAIL wrong_target got=%0b/%h want=1/00000240", o.mp, o.cpc); end
    idle_mem();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if ({o.taken, o.target, o.index} !== {e.taken, e.target, e.index}) begin failures++; $display("FAIL %s lookup got=%0b/%h/%0d want=%0b/%h/%0d", e.name, o.taken, o.target, o.index, e.taken, e.target, e.index); end
      checks++; if (o.mp !== e.mp) begin failures++; $display("FAIL %s mispredict got=%0b want=%0b", e.name, o.mp, e.mp); end
      if (e.mp) begin checks++; if (o.cpc !== e.cpc) begin failures++; $display("FAIL %s correct_pc got=%h want=%h", e.name, o.cpc, e.cpc); end end
      checks++; if ({o.sb, o.sm} !== {e.sb, e.sm}) begin failures++; $display("FAIL %s stats got=%0d/%0d want=%0d/%0d", e.name, o.sb, o.sm, e.sb, e.sm); end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    logic [31:0] pc;
    for (int n = 0; n < 40; n++) begin
      pc = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
      if ($urandom_range(0, 4) == 0) begin
        idle_mem();
      end else begin
        set_upd(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'h2000 + 32'($urandom_range(0, 3)) * 32'd16);
      end
      if_pc = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
      cycle("b2b");
    end
    idle_mem();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if ({o.taken, o.target, o.index} !== {e.taken, e.target, e.index}) begin failures++; $display("FAIL %s lookup got=%0b/%h/%0d want=%0b/%h/%0d", e.name, o.taken, o.target, o.index, e.taken, e.target, e.index); end
      checks++; if (o.mp !== e.mp) begin failures++; $display("FAIL %s mispredict got=%0b want=%0b", e.name, o.mp, e.mp); end
      if (e.mp) begin checks++; if (o.cpc !== e.cpc) begin failures++; $display("FAIL %s correct_pc got=%h want=%h", e.name, o.cpc, e.cpc); end end
      checks++; if ({o.sb, o.sm} !== {e.sb, e.sm}) begin failures++; $display("FAIL %s stats got=%0d/%0d want=%0d/%0d", e.name, o.sb, o.sm, e.sb, e.sm); end
    end
  endtask

  task automatic test_async_reset();
    rec_t e, o;
    if_pc = 32'h58;
    for (int i = 0; i < 3; i++) begin
      set_upd(32'h58, 1'b0, 1'b1, 32'h200);
      cycle("pre_reset");
    end
    idle_mem();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checks++; if ({btb_taken, btb_target, btb_index} !== {1'b0, 32'h5C, 2'd2}) begin failures++; $display("FAIL async_reset_lookup got=%0b/%h/%0d want=0/0000005c/2", btb_taken, btb_target, btb_index); end
    checks++; if ({stat_branches, stat_mispredicts} !== 64'd0) begin failures++; $display("FAIL async_reset_stats got=%0d/%0d want=0/0", stat_branches, stat_mispredicts); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL async_reset_mispredict got=%0b want=0", mispredict); end
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    if_pc = 32'h58;
    cycle("post_reset_58");
    o = obs_q[$];
    checks++; if ({o.taken, o.target} !== {1'b0, 32'h5C}) begin failures++; $display("FAIL post_reset_miss got=%0b/%h want=0/0000005c", o.taken, o.target); end
    for (int k = 0; k < 8; k++) begin
      if_pc = 32'h1000 + 32'(k) * 32'd4;
      cycle("post_reset_scan");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if ({o.taken, o.target, o.index} !== {e.taken, e.target, e.index}) begin failures++; $display("FAIL %s lookup got=%0b/%h/%0d want=%0b/%h/%0d", e.name, o.taken, o.target, o.index, e.taken, e.target, e.index); end
      checks++; if (o.mp !== e.mp) begin failures++; $display("FAIL %s mispredict got=%0b want=%0b", e.name, o.mp, e.mp); end
      if (e.mp) begin checks++; if (o.cpc !== e.cpc) begin failures++; $display("FAIL %s correct_pc got=%h want=%h", e.name, o.cpc, e.cpc); end end
      checks++; if ({o.sb, o.sm} !== {e.sb, e.sm}) begin failures++; $display("FAIL %s stats got=%0d/%0d want=%0d/%0d", e.name, o.sb, o.sm, e.sb, e.sm); end
    end
  endtask

  initial begin
    RST = 1'b1;
    if_pc = 32'h0;
    mem_valid = 1'b0; mem_beq = 1'b0; mem_bne = 1'b0;
    mem_pc = 32'h0; mem_brTake = 1'b0; mem_brTarget = 32'h0;
    mem_btb_taken = 1'b0; mem_btb_target = 32'h0; mem_btb_index = 2'd0;
    #12;
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
